// File: rtl/spi_peripheral.sv
// SPI mode-0 peripheral (CPOL=0, CPHA=0, MSB first), oversampled in the clk domain.
// Optional build macro SPI_PERIPHERAL_ECHO_EN reloads an empty TX buffer with each received word.
module spi_peripheral #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    input  logic                  txWrEn,
    input  logic [DATA_WIDTH-1:0] txData,
    output logic                  txEmpty,
    output logic [DATA_WIDTH-1:0] rxData,
    output logic                  rxValid,
    input  logic                  rxRdEn,
    output logic                  rxOverrun
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {StWaitCs, StIdle, StShift, StDone} state_t;

    state_t state_q, state_d;

    // [0],[1] synchronize; [2] is the history flop for edge detection.
    logic [2:0] sclk_pipe, cs_pipe;
    logic [1:0] mosi_pipe;

    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0] tx_buf_q, tx_buf_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  tx_empty_q, tx_empty_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  rx_overrun_q, rx_overrun_d;
    logic                  load_tx;

    logic sclk_rise, sclk_fall, cs_sync, cs_fall, cs_rise, mosi_sync;

    assign sclk_rise = sclk_pipe[1] & ~sclk_pipe[2];
    assign sclk_fall = ~sclk_pipe[1] & sclk_pipe[2];
    assign cs_sync   = cs_pipe[1];
    assign cs_fall   = ~cs_pipe[1] & cs_pipe[2];
    assign cs_rise   = cs_pipe[1] & ~cs_pipe[2];
    assign mosi_sync = mosi_pipe[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StWaitCs;
            sclk_pipe    <= '0;
            cs_pipe      <= '0;
            mosi_pipe    <= '0;
            bit_cnt_q    <= '0;
            rx_shift_q   <= '0;
            tx_shift_q   <= '0;
            tx_buf_q     <= '0;
            rx_data_q    <= '0;
            tx_empty_q   <= 1'b1;
            rx_valid_q   <= 1'b0;
            rx_overrun_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sclk_pipe    <= {sclk_pipe[1:0], sclk};
            cs_pipe      <= {cs_pipe[1:0], cs_n};
            mosi_pipe    <= {mosi_pipe[0], mosi};
            bit_cnt_q    <= bit_cnt_d;
            rx_shift_q   <= rx_shift_d;
            tx_shift_q   <= tx_shift_d;
            tx_buf_q     <= tx_buf_d;
            rx_data_q    <= rx_data_d;
            tx_empty_q   <= tx_empty_d;
            rx_valid_q   <= rx_valid_d;
            rx_overrun_q <= rx_overrun_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        rx_shift_d   = rx_shift_q;
        tx_shift_d   = tx_shift_q;
        tx_buf_d     = tx_buf_q;
        rx_data_d    = rx_data_q;
        tx_empty_d   = tx_empty_q;
        rx_valid_d   = rx_valid_q;
        rx_overrun_d = rx_overrun_q;
        load_tx      = 1'b0;

        // A read is applied first so a same-cycle DONE write overrides it.
        if (rxRdEn) rx_valid_d = 1'b0;

        unique case (state_q)
            StWaitCs: begin
                if (cs_sync) state_d = StIdle;
            end
            StIdle: begin
                if (cs_fall) begin
                    state_d = StShift;
                    load_tx = 1'b1;
                end
            end
            StShift: begin
                if (cs_rise) begin
                    state_d = StIdle;
                end else begin
                    if (sclk_rise) begin
                        rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_sync};
                        bit_cnt_d  = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) state_d = StDone;
                    end
                    // Hold the MSB until the first rising edge of the word.
                    if (sclk_fall && bit_cnt_q != '0) begin
                        tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
                    end
                end
            end
            StDone: begin
                rx_data_d  = rx_shift_q;
                rx_valid_d = 1'b1;
                if (rx_valid_q && !rxRdEn) rx_overrun_d = 1'b1;
                if (!cs_sync) begin
                    state_d = StShift;
                    load_tx = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StWaitCs;
        endcase

        if (load_tx) begin
            tx_shift_d = tx_empty_q ? '0 : tx_buf_q;
            tx_empty_d = 1'b1;
            bit_cnt_d  = '0;
        end

`ifdef SPI_PERIPHERAL_ECHO_EN
        if (state_q == StDone && tx_empty_q && !txWrEn) begin
            tx_buf_d   = rx_shift_q;
            tx_empty_d = 1'b0;
        end
`endif

        if (txWrEn) begin
            tx_buf_d   = txData;
            tx_empty_d = 1'b0;
        end
    end

    assign miso      = ((state_q == StShift) || (state_q == StDone)) && !cs_sync ?
                       tx_shift_q[DATA_WIDTH-1] : 1'b0;
    assign txEmpty   = tx_empty_q;
    assign rxData    = rx_data_q;
    assign rxValid   = rx_valid_q;
    assign rxOverrun = rx_overrun_q;

endmodule

// File: tb/tb_spi_peripheral.sv
// Self-checking bench for spi_peripheral: frame-level model plus directed SPI controller frames.
// Honours SPI_PERIPHERAL_ECHO_EN for the expected transmit data.
module tb_spi_peripheral;

    localparam int W = 8;

    logic         clk    = 1'b0;
    logic         rst    = 1'b1;
    logic         sclk   = 1'b0;
    logic         cs_n   = 1'b1;
    logic         mosi   = 1'b0;
    logic         txWrEn = 1'b0;
    logic         rxRdEn = 1'b0;
    logic [W-1:0] txData = '0;
    logic         miso, txEmpty, rxValid, rxOverrun;
    logic [W-1:0] rxData;

    spi_peripheral #(.DATA_WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .sclk      (sclk),
        .cs_n      (cs_n),
        .mosi      (mosi),
        .miso      (miso),
        .txWrEn    (txWrEn),
        .txData    (txData),
        .txEmpty   (txEmpty),
        .rxData    (rxData),
        .rxValid   (rxValid),
        .rxRdEn    (rxRdEn),
        .rxOverrun (rxOverrun)
    );

    always #5 clk = ~clk;

    // Frame-level model of the host-visible state.
    logic [W-1:0] m_rx_data  = '0;
    logic [W-1:0] m_tx_buf   = '0;
    bit           m_rx_valid = 1'b0;
    bit           m_overrun  = 1'b0;
    bit           m_tx_empty = 1'b1;
    bit           check_en   = 1'b0;
    int           n_checks   = 0;
    int           n_fail     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Steady-state compare whenever no frame or reset is in flight.
    always begin
        @(posedge clk);
        #2;
        if (check_en) begin
            check("rxValid", rxValid, m_rx_valid);
            check("rxData", rxData, m_rx_data);
            check("rxOverrun", rxOverrun, m_overrun);
            check("txEmpty", txEmpty, m_tx_empty);
            if (cs_n) check("miso_idle", miso, 0);
        end
    end

    task automatic model_reset();
        m_rx_data  = '0;
        m_tx_buf   = '0;
        m_rx_valid = 1'b0;
        m_overrun  = 1'b0;
        m_tx_empty = 1'b1;
    endtask

    task automatic do_reset();
        check_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (5) @(negedge clk);
        check_en = 1'b1;
    endtask

    task automatic host_read();
        @(negedge clk);
        rxRdEn = 1'b1;
        m_rx_valid = 1'b0;
        @(negedge clk);
        rxRdEn = 1'b0;
    endtask

    task automatic host_write(input logic [W-1:0] d);
        @(negedge clk);
        txWrEn = 1'b1;
        txData = d;
        m_tx_buf = d;
        m_tx_empty = 1'b0;
        @(negedge clk);
        txWrEn = 1'b0;
    endtask

    // One cs_n assertion carrying nw words (1 or 2); abort_after>0 raises cs_n after that many bits.
    task automatic frame(input int nw, input logic [W-1:0] w0, input logic [W-1:0] w1,
                         input int abort_after, input bit rd_mid,
                         output logic [W-1:0] g0, output logic [W-1:0] g1);
        logic [W-1:0] wd, got, exp_miso;
        bit was_empty;
        int nbits;
        bit aborted;
        nbits = 0;
        aborted = 1'b0;
        g0 = '0;
        g1 = '0;
        check_en = 1'b0;
        @(negedge clk);
        cs_n = 1'b0;
        exp_miso = m_tx_empty ? '0 : m_tx_buf;
        m_tx_empty = 1'b1;
        #40;
        check("txEmpty_at_cs_fall", txEmpty, m_tx_empty);
        #10;
        for (int i = 0; i < nw; i++) begin
            wd = (i == 0) ? w0 : w1;
            got = '0;
            for (int b = W - 1; b >= 0; b--) begin
                if (abort_after > 0 && nbits == abort_after) begin
                    aborted = 1'b1;
                    break;
                end
                mosi = wd[b];
                if (rd_mid && i == 1 && b == W - 1) begin
                    rxRdEn = 1'b1;
                    m_rx_valid = 1'b0;
                    #10;
                    rxRdEn = 1'b0;
                    #40;
                end else begin
                    #50;
                end
                sclk = 1'b1;
                got[b] = miso;
                #50;
                sclk = 1'b0;
                nbits++;
            end
            if (aborted) break;
            if (m_rx_valid) m_overrun = 1'b1;
            m_rx_valid = 1'b1;
            m_rx_data  = wd;
            check("miso_word", got, exp_miso);
            check("rx_word", rxData, m_rx_data);
            check("rx_valid_word", rxValid, m_rx_valid);
            check("rx_overrun_word", rxOverrun, m_overrun);
            // cs_n is still low at the end of each word, so the buffer is reloaded.
            was_empty  = m_tx_empty;
            exp_miso   = was_empty ? '0 : m_tx_buf;
            m_tx_empty = 1'b1;
`ifdef SPI_PERIPHERAL_ECHO_EN
            if (was_empty) begin
                m_tx_buf   = wd;
                m_tx_empty = 1'b0;
            end
`endif
            if (i == 0) g0 = got;
            else g1 = got;
        end
        #50;
        cs_n = 1'b1;
        mosi = 1'b0;
        repeat (10) @(negedge clk);
        check_en = 1'b1;
    endtask

    logic [W-1:0] g0, g1, echo_exp, tmp;

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_miso", miso, 0);
        check("reset_txEmpty", txEmpty, 1);
        check("reset_rxData", rxData, 0);
        check("reset_rxValid", rxValid, 0);
        check("reset_rxOverrun", rxOverrun, 0);
        repeat (5) @(negedge clk);
        check_en = 1'b1;

        // Plain frame with empty TX buffer
        frame(1, 8'h0A, 8'h00, 0, 1'b0, g0, g1);
        check("t1_rxData", rxData, 8'h0A);
        check("t1_rxValid", rxValid, 1);
        check("t1_miso", g0, 8'h00);
        check("t1_overrun", rxOverrun, 0);
        host_read();

        // Buffered TX word
        host_write(8'hA5);
        #1;
        check("t2_txEmpty_loaded", txEmpty, 0);
        frame(1, 8'h3C, 8'h00, 0, 1'b0, g0, g1);
        check("t2_miso", g0, 8'hA5);
        check("t2_rxData", rxData, 8'h3C);
        host_read();

        // Back-to-back without read -> overrun
        frame(2, 8'h11, 8'h22, 0, 1'b0, g0, g1);
        check("t3_rxData", rxData, 8'h22);
        check("t3_overrun", rxOverrun, 1);
        do_reset();

        // Back-to-back with a read between words -> no overrun
        frame(2, 8'h11, 8'h22, 0, 1'b1, g0, g1);
        check("t4_rxData", rxData, 8'h22);
        check("t4_overrun", rxOverrun, 0);
        host_read();

        // Aborted frame after 5 bits
        frame(1, 8'hFF, 8'h00, 5, 1'b0, g0, g1);
        check("t5_abort_valid", rxValid, 0);
        check("t5_abort_data", rxData, 8'h22);
        frame(1, 8'h81, 8'h00, 0, 1'b0, g0, g1);
        check("t5_rxData", rxData, 8'h81);
        host_read();

        // Reset in the middle of a frame with cs_n held low
        check_en = 1'b0;
        @(negedge clk);
        cs_n = 1'b0;
        #50;
        tmp = 8'hF0;
        for (int b = W - 1; b >= 0; b--) begin
            if (b == 3) begin
                rst = 1'b1;
                repeat (2) @(negedge clk);
                rst = 1'b0;
                model_reset();
            end
            mosi = tmp[b];
            #50;
            sclk = 1'b1;
            if (b < 3) check("t6_miso_wait_cs", miso, 0);
            #50;
            sclk = 1'b0;
        end
        #50;
        cs_n = 1'b1;
        mosi = 1'b0;
        repeat (10) @(negedge clk);
        check("t6_no_valid", rxValid, 0);
        check_en = 1'b1;
        frame(1, 8'h55, 8'h00, 0, 1'b0, g0, g1);
        check("t6_rxData", rxData, 8'h55);

        // Echo behaviour
        do_reset();
        frame(1, 8'hC3, 8'h00, 0, 1'b0, g0, g1);
        check("t7_first_miso", g0, 8'h00);
        frame(1, 8'h00, 8'h00, 0, 1'b0, g0, g1);
`ifdef SPI_PERIPHERAL_ECHO_EN
        echo_exp = 8'hC3;
`else
        echo_exp = 8'h00;
`endif
        check("t7_echo_miso", g0, echo_exp);
        check("t7_rxData", rxData, 8'h00);
        check("t7_overrun", rxOverrun, 1);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
